// File: rtl/sys_bridge.sv
// -----------------------------------------------------------------------------
// sys_bridge
// Processor-to-device bridge between the multi-cycle MIPS core and N_DEV
// memory-mapped peripherals. Decodes the address windows and runs a
// request/ack handshake with a timeout on each access. Read data is returned
// with a one-cycle PrReady pulse. Device interrupt lines are folded into
// HWInt[5:0].
//
// Optional feature: define SYS_BRIDGE_IRQ_LATCH_EN to enable sticky interrupt
// pending bits. These are exposed through an extra internal window at
// BASE + (N_DEV << WIN_W): a read returns the pending bits and a write clears
// them (write-1-to-clear).
//
// Ports
//   clk, rst      clock (rising edge), synchronous active-high reset
//   PrAddr/PrWD   CPU byte address / write data, held until PrReady
//   Wen/Ren       CPU write / read request, held until PrReady
//   PrRD          read data, valid with PrReady
//   PrReady       one-cycle access-complete pulse
//   BusErr        qualifies PrReady: address miss or device timeout
//   DEV_Addr      offset inside the selected window
//   DEV_WD        write data to the devices
//   DEV_WE/DEV_RE one-hot write / read strobes
//   DEV_RD        packed device read data, slot i at [i*DATA_W +: DATA_W]
//   DEV_Ack       device completion, only the selected slot is honoured
//   DEV_Irq       level interrupt requests
//   HWInt         interrupt lines to CP0
// -----------------------------------------------------------------------------
module sys_bridge #(
  parameter int          N_DEV   = 4,
  parameter int          DATA_W  = 32,
  parameter int          WIN_W   = 4,
  parameter logic [31:0] BASE    = 32'h00007F00,
  parameter int          TIMEOUT = 15
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [31:0]             PrAddr,
  input  logic [DATA_W-1:0]       PrWD,
  input  logic                    Wen,
  input  logic                    Ren,
  output logic [DATA_W-1:0]       PrRD,
  output logic                    PrReady,
  output logic                    BusErr,
  output logic [WIN_W-1:0]        DEV_Addr,
  output logic [DATA_W-1:0]       DEV_WD,
  output logic [N_DEV-1:0]        DEV_WE,
  output logic [N_DEV-1:0]        DEV_RE,
  input  logic [N_DEV*DATA_W-1:0] DEV_RD,
  input  logic [N_DEV-1:0]        DEV_Ack,
  input  logic [N_DEV-1:0]        DEV_Irq,
  output logic [5:0]              HWInt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [31:0] DEV_SPAN = 32'(N_DEV) << WIN_W;
  localparam logic [31:0] WIN_SIZE = 32'd1 << WIN_W;
  localparam logic [7:0]  CNT_LAST = 8'(TIMEOUT - 1);

  state_t              state_r;
  logic [7:0]          cnt_r;
  logic [N_DEV-1:0]    sel_r;
  logic                wr_r;
  logic                int_r;      // access targets the internal pending window
  logic                ignore_r;   // skip the still-held request right after DONE
  logic [DATA_W-1:0]   pr_rd_r;
  logic                pr_ready_r;
  logic                bus_err_r;
  logic [WIN_W-1:0]    dev_addr_r;
  logic [DATA_W-1:0]   dev_wd_r;
  logic [N_DEV-1:0]    dev_we_r;
  logic [N_DEV-1:0]    dev_re_r;

  logic [31:0]         off_s;
  logic                above_base_s;
  logic                dev_hit_s;
  logic                int_hit_s;
  logic [2:0]          slot_s;
  logic [N_DEV-1:0]    sel_s;
  logic                ack_s;
  logic [DATA_W-1:0]   dev_rd_s;
  logic [DATA_W-1:0]   pend_rd_s;

  // Address decode: the full 32-bit address is compared, so aliases above the window miss.
  always_comb begin
    off_s        = PrAddr - BASE;
    above_base_s = (PrAddr >= BASE);
    dev_hit_s    = above_base_s && (off_s < DEV_SPAN);
    slot_s       = 3'(off_s >> WIN_W);
    sel_s        = '0;
    for (int i = 0; i < N_DEV; i++) begin
      sel_s[i] = dev_hit_s && (slot_s == 3'(i));
    end
  end

  // Ack qualification and read-data mux for the latched slot.
  always_comb begin
    ack_s    = |(DEV_Ack & sel_r);
    dev_rd_s = '0;
    for (int i = 0; i < N_DEV; i++) begin
      dev_rd_s = dev_rd_s | (DEV_RD[i*DATA_W +: DATA_W] & {DATA_W{sel_r[i]}});
    end
  end

`ifdef SYS_BRIDGE_IRQ_LATCH_EN
  logic [N_DEV-1:0] irq_s1_r;
  logic [N_DEV-1:0] irq_s2_r;
  logic [N_DEV-1:0] irq_pend_r;
  logic [N_DEV-1:0] irq_clr_s;

  // Internal window decode and W1C mask taken from the latched write data.
  always_comb begin
    int_hit_s = above_base_s && (off_s >= DEV_SPAN) && (off_s < (DEV_SPAN + WIN_SIZE));
    pend_rd_s = DATA_W'(irq_pend_r);
    if ((state_r == REQ) && int_r && wr_r) begin
      irq_clr_s = dev_wd_r[N_DEV-1:0];
    end else begin
      irq_clr_s = '0;
    end
  end

  // Sticky pending bits: rising edge of the registered request sets, W1C clears, set wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      irq_s1_r   <= '0;
      irq_s2_r   <= '0;
      irq_pend_r <= '0;
    end else begin
      irq_s1_r   <= DEV_Irq;
      irq_s2_r   <= irq_s1_r;
      irq_pend_r <= (irq_pend_r & ~irq_clr_s) | (irq_s1_r & ~irq_s2_r);
    end
  end

  assign HWInt = 6'(irq_pend_r);
`else
  logic [5:0] hw_int_r;

  // Without the pending window the extra address range is simply a miss.
  always_comb begin
    int_hit_s = 1'b0;
    pend_rd_s = '0;
  end

  // Level interrupts registered once; unused upper lines stay low.
  always_ff @(posedge clk) begin
    if (rst) begin
      hw_int_r <= 6'd0;
    end else begin
      hw_int_r <= 6'(DEV_Irq);
    end
  end

  assign HWInt = hw_int_r;
`endif

  // Access FSM: IDLE -> REQ -> DONE -> IDLE, all bus outputs registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      cnt_r      <= 8'd0;
      sel_r      <= '0;
      wr_r       <= 1'b0;
      int_r      <= 1'b0;
      ignore_r   <= 1'b0;
      pr_rd_r    <= '0;
      pr_ready_r <= 1'b0;
      bus_err_r  <= 1'b0;
      dev_addr_r <= '0;
      dev_wd_r   <= '0;
      dev_we_r   <= '0;
      dev_re_r   <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          pr_ready_r <= 1'b0;
          bus_err_r  <= 1'b0;
          if (ignore_r) begin
            ignore_r <= 1'b0;
          end else if (Wen || Ren) begin
            // Wen wins when both are raised together.
            wr_r       <= Wen;
            dev_addr_r <= PrAddr[WIN_W-1:0];
            dev_wd_r   <= PrWD;
            sel_r      <= sel_s;
            int_r      <= int_hit_s;
            cnt_r      <= 8'd0;
            if (dev_hit_s) begin
              state_r <= REQ;
              if (Wen) begin
                dev_we_r <= sel_s;
              end else begin
                dev_re_r <= sel_s;
              end
            end else if (int_hit_s) begin
              state_r <= REQ;
            end else begin
              state_r    <= DONE;
              pr_rd_r    <= '0;
              pr_ready_r <= 1'b1;
              bus_err_r  <= 1'b1;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        REQ: begin
          if (int_r) begin
            state_r    <= DONE;
            pr_rd_r    <= wr_r ? '0 : pend_rd_s;
            pr_ready_r <= 1'b1;
            bus_err_r  <= 1'b0;
          end else if (ack_s) begin
            state_r    <= DONE;
            dev_we_r   <= '0;
            dev_re_r   <= '0;
            pr_rd_r    <= wr_r ? '0 : dev_rd_s;
            pr_ready_r <= 1'b1;
            bus_err_r  <= 1'b0;
          end else if (cnt_r == CNT_LAST) begin
            state_r    <= DONE;
            dev_we_r   <= '0;
            dev_re_r   <= '0;
            pr_rd_r    <= '0;
            pr_ready_r <= 1'b1;
            bus_err_r  <= 1'b1;
          end else begin
            cnt_r <= cnt_r + 8'd1;
          end
        end
        DONE: begin
          state_r    <= IDLE;
          pr_ready_r <= 1'b0;
          bus_err_r  <= 1'b0;
          ignore_r   <= 1'b1;
        end
        default: begin
          state_r    <= IDLE;
          pr_ready_r <= 1'b0;
          bus_err_r  <= 1'b0;
          dev_we_r   <= '0;
          dev_re_r   <= '0;
        end
      endcase
    end
  end

  assign PrRD     = pr_rd_r;
  assign PrReady  = pr_ready_r;
  assign BusErr   = bus_err_r;
  assign DEV_Addr = dev_addr_r;
  assign DEV_WD   = dev_wd_r;
  assign DEV_WE   = dev_we_r;
  assign DEV_RE   = dev_re_r;

endmodule

// File: tb/tb_sys_bridge.sv
// Testbench for sys_bridge: a scoreboard queue holds the expected {PrRD, BusErr}
// for every issued access and is compared on each PrReady pulse. Strobes,
// latency and interrupt lines are checked directly.
module tb_sys_bridge;

  logic          clk;
  logic          rst;
  logic [31:0]   PrAddr;
  logic [31:0]   PrWD;
  logic          Wen;
  logic          Ren;
  logic [31:0]   PrRD;
  logic          PrReady;
  logic          BusErr;
  logic [3:0]    DEV_Addr;
  logic [31:0]   DEV_WD;
  logic [3:0]    DEV_WE;
  logic [3:0]    DEV_RE;
  logic [127:0]  DEV_RD;
  logic [3:0]    DEV_Ack;
  logic [3:0]    DEV_Irq;
  logic [5:0]    HWInt;

  int            checks;
  int            failures;
  logic [32:0]   sb_q[$];
  int            ack_after;
  int            strobe_cyc;
  logic [3:0]    noise_ack;

  sys_bridge dut (
    .clk(clk), .rst(rst), .PrAddr(PrAddr), .PrWD(PrWD), .Wen(Wen), .Ren(Ren),
    .PrRD(PrRD), .PrReady(PrReady), .BusErr(BusErr), .DEV_Addr(DEV_Addr),
    .DEV_WD(DEV_WD), .DEV_WE(DEV_WE), .DEV_RE(DEV_RE), .DEV_RD(DEV_RD),
    .DEV_Ack(DEV_Ack), .DEV_Irq(DEV_Irq), .HWInt(HWInt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Device model: acks the strobed slot in the ack_after-th strobe cycle (0 = never).
  always @(posedge clk) begin
    #1;
    if ((DEV_WE | DEV_RE) != 4'b0000) begin
      strobe_cyc = strobe_cyc + 1;
      if ((ack_after != 0) && (strobe_cyc == ack_after)) DEV_Ack = (DEV_WE | DEV_RE) | noise_ack;
      else DEV_Ack = noise_ack;
    end else begin
      strobe_cyc = 0;
      DEV_Ack = noise_ack;
    end
  end

  // Scoreboard: every PrReady pulse pops one expected {PrRD, BusErr}.
  always @(negedge clk) begin
    logic [32:0] e;
    if (PrReady === 1'b1) begin
      if (sb_q.size() == 0) begin
        check_val("sb_unexpected_ready", {63'd0, PrReady}, 64'd0);
      end else begin
        e = sb_q.pop_front();
        check_val("sb_prrd", {32'd0, PrRD}, {32'd0, e[32:1]});
        check_val("sb_buserr", {63'd0, BusErr}, {63'd0, e[0]});
      end
    end
  end

  task automatic do_access(input string name, input logic w, input logic r,
                           input logic [31:0] addr, input logic [31:0] wd, input int ackn,
                           input logic [31:0] exp_rd, input logic exp_err,
                           input logic [3:0] exp_we, input logic [3:0] exp_re,
                           input int exp_scyc, input int exp_lat);
    int lat;
    int scyc;
    logic [3:0] we_m;
    logic [3:0] re_m;
    logic [3:0] addr_o;
    logic [31:0] wd_o;
    bit done;
    @(posedge clk); #1;
    ack_after = ackn;
    PrAddr = addr; PrWD = wd; Wen = w; Ren = r;
    sb_q.push_back({exp_rd, exp_err});
    lat = -1; scyc = 0; we_m = 4'd0; re_m = 4'd0; addr_o = 4'd0; wd_o = 32'd0; done = 1'b0;
    for (int n = 0; n < 40 && !done; n++) begin
      @(negedge clk);
      if ((DEV_WE | DEV_RE) != 4'b0000) begin
        if (scyc == 0) begin addr_o = DEV_Addr; wd_o = DEV_WD; end
        scyc++;
        we_m = we_m | DEV_WE;
        re_m = re_m | DEV_RE;
      end
      if (PrReady === 1'b1) begin lat = n; done = 1'b1; end
    end
    Wen = 1'b0; Ren = 1'b0;
    check_val({name, "_latency"}, 64'(lat), 64'(exp_lat));
    check_val({name, "_strobe_mask"}, {56'd0, we_m, re_m}, {56'd0, exp_we, exp_re});
    check_val({name, "_strobe_cycles"}, 64'(scyc), 64'(exp_scyc));
    if (exp_scyc != 0) begin
      check_val({name, "_dev_addr"}, {60'd0, addr_o}, {60'd0, addr[3:0]});
      check_val({name, "_dev_wd"}, {32'd0, wd_o}, {32'd0, wd});
    end
    @(negedge clk);
    check_val({name, "_ready_single"}, {63'd0, PrReady}, 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks = 0; failures = 0; ack_after = 0; strobe_cyc = 0; noise_ack = 4'd0;
    rst = 1'b1; PrAddr = 32'd0; PrWD = 32'd0; Wen = 1'b0; Ren = 1'b0;
    DEV_Ack = 4'd0; DEV_Irq = 4'd0;
    DEV_RD = {32'hA5A50003, 32'h12345678, 32'h11110001, 32'hCAFE0000};
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_prready", {63'd0, PrReady}, 64'd0);
    check_val("rst_buserr", {63'd0, BusErr}, 64'd0);
    check_val("rst_prrd", {32'd0, PrRD}, 64'd0);
    check_val("rst_strobes", {56'd0, DEV_WE, DEV_RE}, 64'd0);
    check_val("rst_dev_addr_wd", {28'd0, DEV_Addr, DEV_WD}, 64'd0);
    check_val("rst_hwint", {58'd0, HWInt}, 64'd0);
    rst = 1'b0;

    // Main accesses: write/read hits, miss, Wen&Ren, timeout with stray ack.
    do_access("wr_slot1", 1'b1, 1'b0, 32'h00007F14, 32'hDEADBEEF, 1, 32'd0, 1'b0, 4'b0010, 4'b0000, 1, 2);
    do_access("rd_slot2", 1'b0, 1'b1, 32'h00007F28, 32'h0, 3, 32'h12345678, 1'b0, 4'b0000, 4'b0100, 3, 4);
    do_access("rd_miss_low", 1'b0, 1'b1, 32'h00007E00, 32'h0, 1, 32'd0, 1'b1, 4'b0000, 4'b0000, 0, 1);
    do_access("rd_miss_edge", 1'b0, 1'b1, 32'h00007EFF, 32'h0, 1, 32'd0, 1'b1, 4'b0000, 4'b0000, 0, 1);
    do_access("rd_miss_alias", 1'b0, 1'b1, 32'h00017F04, 32'h0, 1, 32'd0, 1'b1, 4'b0000, 4'b0000, 0, 1);
    do_access("rd_slot3", 1'b0, 1'b1, 32'h00007F3C, 32'h0, 1, 32'hA5A50003, 1'b0, 4'b0000, 4'b1000, 1, 2);
    do_access("wr_rd_both", 1'b1, 1'b1, 32'h00007F08, 32'h5A5A0101, 2, 32'd0, 1'b0, 4'b0001, 4'b0000, 2, 3);
    noise_ack = 4'b0001;
    do_access("wr_timeout", 1'b1, 1'b0, 32'h00007F30, 32'h00000077, 0, 32'd0, 1'b1, 4'b1000, 4'b0000, 15, 16);
    noise_ack = 4'b0000;

    // Reset during the second REQ cycle aborts the access.
    @(posedge clk); #1;
    ack_after = 0; PrAddr = 32'h00007F18; Ren = 1'b1; DEV_Irq = 4'b1111;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check_val("pre_rst_strobe", {60'd0, DEV_RE}, {60'd0, 4'b0010});
    check_val("pre_rst_hwint", {58'd0, HWInt}, {58'd0, 6'b001111});
    @(posedge clk); #1;
    rst = 1'b0; Ren = 1'b0; DEV_Irq = 4'b0000;
    @(negedge clk);
    check_val("post_rst_strobes", {56'd0, DEV_WE, DEV_RE}, 64'd0);
    check_val("post_rst_prready", {63'd0, PrReady}, 64'd0);
    check_val("post_rst_hwint", {58'd0, HWInt}, 64'd0);
    do_access("rd_after_rst", 1'b0, 1'b1, 32'h00007F04, 32'h0, 2, 32'hCAFE0000, 1'b0, 4'b0000, 4'b0001, 2, 3);

    // Interrupt pulse on slots 0 and 2.
    @(posedge clk); #1;
    DEV_Irq = 4'b0101;
    @(negedge clk);
    check_val("irq_c0", {58'd0, HWInt}, 64'd0);
    @(posedge clk); #1;
    DEV_Irq = 4'b0000;
`ifdef SYS_BRIDGE_IRQ_LATCH_EN
    @(negedge clk);
    check_val("irq_c1", {58'd0, HWInt}, 64'd0);
    repeat (4) @(negedge clk);
    check_val("irq_sticky", {58'd0, HWInt}, {58'd0, 6'b000101});
    do_access("rd_pend", 1'b0, 1'b1, 32'h00007F40, 32'h0, 1, 32'd5, 1'b0, 4'b0000, 4'b0000, 0, 2);
    do_access("w1c_pend", 1'b1, 1'b0, 32'h00007F40, 32'h1, 1, 32'd0, 1'b0, 4'b0000, 4'b0000, 0, 2);
    check_val("irq_after_w1c", {58'd0, HWInt}, {58'd0, 6'b000100});
`else
    @(negedge clk);
    check_val("irq_c1", {58'd0, HWInt}, {58'd0, 6'b000101});
    @(negedge clk);
    check_val("irq_c2", {58'd0, HWInt}, 64'd0);
    do_access("rd_extra_win", 1'b0, 1'b1, 32'h00007F40, 32'h0, 1, 32'd0, 1'b1, 4'b0000, 4'b0000, 0, 1);
`endif

    repeat (3) @(negedge clk);
    check_val("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
